// File: rtl/disp_pkg.sv
// disp_pkg: glyph codes, result codes, sequencer states and the banner lookup
package disp_pkg;
  localparam logic [3:0] G_0 = 4'b0000;
  localparam logic [3:0] G_1 = 4'b0001;
  localparam logic [3:0] G_2 = 4'b0010;
  localparam logic [3:0] G_P = 4'b0100;
  localparam logic [3:0] G_R = 4'b0101;
  localparam logic [3:0] G_S = 4'b0110;
  localparam logic [3:0] G_DASH = 4'b1000;
  localparam logic [3:0] G_OFF = 4'b1111;
  localparam logic [1:0] RES_P1 = 2'b00;
  localparam logic [1:0] RES_P2 = 2'b01;
  localparam logic [1:0] RES_TIE = 2'b10;
  typedef enum logic [1:0] {LIVE, SHOW, GAP} state_t;
  function automatic logic [15:0] banner(input logic [1:0] code);
    return code == RES_P1 ? {G_DASH, G_P, G_1, G_DASH} :
           code == RES_P2 ? {G_DASH, G_P, G_2, G_DASH} : {4{G_DASH}};
  endfunction
endpackage

// File: rtl/disp_if.sv
// disp_if: game-logic side and scanner side signals of the display sequencer
interface disp_if;
  logic [3:0] live_d1, live_d2, live_d3, live_d4;
  logic res_req;
  logic [1:0] res_code;
  logic [3:0] d1, d2, d3, d4;
  logic scan_clk;
  logic busy;
  modport master(
    output live_d1, live_d2, live_d3, live_d4, res_req, res_code,
    input d1, d2, d3, d4, scan_clk, busy
  );
  modport slave(
    input live_d1, live_d2, live_d3, live_d4, res_req, res_code,
    output d1, d2, d3, d4, scan_clk, busy
  );
endinterface

// File: rtl/disp_seq_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every DIV clocks, restartable by clr
module tick_gen #(
  parameter int DIV = 100000
) (
  input logic clk,
  input logic rst,
  input logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (clr || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/disp_seq.sv
// disp_seq: scan clock divider and live/blinking-result glyph selector for the digit scanner
module disp_seq
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int TICK_DIV = 100000,
  parameter int BLINK_TICKS = 250,
  parameter int HOLD_TICKS = 1500
) (
  input logic clk,
  input logic rst,
  disp_if.slave bus
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int PW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic [SW-1:0] r_scan_cnt;
  logic r_scan_clk;
  logic w_tick;
  state_t r_state, w_state;
  logic [PW-1:0] r_phase, w_phase;
  logic [HW-1:0] r_hold, w_hold;
  logic [1:0] r_code, w_code;
  logic [15:0] r_d, w_d;
  logic w_hold_end, w_blink_end, w_live;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_scan_cnt <= '0;
      r_scan_clk <= 1'b0;
    end else begin
      r_scan_cnt <= r_scan_cnt == SW'(SCAN_DIV - 1) ? '0 : r_scan_cnt + 1'b1;
      r_scan_clk <= r_scan_cnt == SW'(SCAN_DIV - 1) ? ~r_scan_clk : r_scan_clk;
    end
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(bus.res_req),
    .tick(w_tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= LIVE;
      r_phase <= '0;
      r_hold <= '0;
      r_code <= RES_P1;
      r_d <= {4{G_OFF}};
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_hold <= w_hold;
      r_code <= w_code;
      r_d <= w_d;
    end
  // a new request outranks hold expiry, which outranks the blink toggle
  always_comb begin
    w_live = r_state == LIVE;
    w_hold_end = w_tick && r_hold == HW'(HOLD_TICKS - 1);
    w_blink_end = w_tick && r_phase == PW'(BLINK_TICKS - 1);
    w_code = bus.res_req ? bus.res_code : r_code;
    w_state = bus.res_req ? SHOW :
              w_live || w_hold_end ? LIVE :
              w_blink_end ? (r_state == SHOW ? GAP : SHOW) : r_state;
    w_phase = (bus.res_req || w_live || w_blink_end) ? '0 : r_phase + PW'(w_tick);
    w_hold = (bus.res_req || w_live) ? '0 : r_hold + HW'(w_tick);
  end
  always_comb begin
    w_d = w_state == LIVE ? {bus.live_d1, bus.live_d2, bus.live_d3, bus.live_d4} :
          w_state == SHOW ? banner(w_code) : {4{G_OFF}};
  end
  assign bus.d1 = r_d[15:12];
  assign bus.d2 = r_d[11:8];
  assign bus.d3 = r_d[7:4];
  assign bus.d4 = r_d[3:0];
  assign bus.scan_clk = r_scan_clk;
  assign bus.busy = r_state != LIVE;
endmodule

// File: tb/tb_disp_seq.sv
// tb_disp_seq: randomized checks of disp_seq against a time-based banner model
module tb_disp_seq;
  localparam int SCAN_DIV = 2;
  localparam int TICK_DIV = 4;
  localparam int BLINK_TICKS = 2;
  localparam int HOLD_TICKS = 6;
  localparam int BLINK_CYC = BLINK_TICKS * TICK_DIV;
  localparam int HOLD_CYC = HOLD_TICKS * TICK_DIV;
  logic clk = 1'b0;
  logic rst = 1'b1;
  disp_if bus ();
  disp_seq #(
    .SCAN_DIV(SCAN_DIV),
    .TICK_DIV(TICK_DIV),
    .BLINK_TICKS(BLINK_TICKS),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int scan_n = 0;
  int t = 0;
  bit active = 1'b0;
  logic [1:0] code = 2'b00;
  logic [15:0] exp_d = 16'hFFFF;
  function automatic logic [15:0] pattern(input logic [1:0] c);
    if (c == 2'b00) return 16'h8418;
    if (c == 2'b01) return 16'h8428;
    return 16'h8888;
  endfunction
  function automatic logic [15:0] got_d();
    return {bus.d1, bus.d2, bus.d3, bus.d4};
  endfunction
  function automatic logic exp_scan();
    return ((scan_n / SCAN_DIV) % 2) != 0;
  endfunction
  // banner timeline measured in clock edges since the accepting edge
  task automatic edge_model();
    @(posedge clk);
    scan_n++;
    if (bus.res_req) begin
      active = 1'b1;
      t = 0;
      code = bus.res_code;
    end else if (active) begin
      t++;
      if (t >= HOLD_CYC) active = 1'b0;
    end
    exp_d = !active ? {bus.live_d1, bus.live_d2, bus.live_d3, bus.live_d4} :
            ((t / BLINK_CYC) % 2 == 0) ? pattern(code) : 16'hFFFF;
    #1;
  endtask
  task automatic model_reset();
    active = 1'b0;
    scan_n = 0;
    exp_d = 16'hFFFF;
  endtask
  task automatic rand_live();
    bus.live_d1 = 4'($urandom);
    bus.live_d2 = 4'($urandom);
    bus.live_d3 = 4'($urandom);
    bus.live_d4 = 4'($urandom);
  endtask
  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 3;
    if (got_d() !== 16'hFFFF) begin errors++; $display("FAIL reset_d got=%h exp=ffff", got_d()); end
    if (bus.scan_clk !== 1'b0) begin errors++; $display("FAIL reset_scan got=%b exp=0", bus.scan_clk); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      edge_model();
      checks += 2;
      if (bus.scan_clk !== exp_scan()) begin errors++; $display("FAIL scan_clk cyc=%0d got=%b exp=%b", i, bus.scan_clk, exp_scan()); end
      if (got_d() !== exp_d) begin errors++; $display("FAIL reset_live cyc=%0d got=%h exp=%h", i, got_d(), exp_d); end
    end
  endtask
  task automatic test_live();
    bus.live_d1 = 4'b0100;
    bus.live_d2 = 4'b1000;
    bus.live_d3 = 4'b0001;
    bus.live_d4 = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      edge_model();
      checks += 2;
      if (got_d() !== exp_d) begin errors++; $display("FAIL live cyc=%0d got=%h exp=%h", i, got_d(), exp_d); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL live_busy cyc=%0d got=%b exp=0", i, bus.busy); end
      rand_live();
    end
  endtask
  task automatic run_banner(input logic [1:0] c, input int cycles, input string name);
    bus.res_req = 1'b1;
    bus.res_code = c;
    for (int i = 0; i < cycles; i++) begin
      edge_model();
      bus.res_req = 1'b0;
      checks += 2;
      if (got_d() !== exp_d) begin errors++; $display("FAIL %s_d cyc=%0d got=%h exp=%h", name, i, got_d(), exp_d); end
      if (bus.busy !== active) begin errors++; $display("FAIL %s_busy cyc=%0d got=%b exp=%b", name, i, bus.busy, active); end
      if (i % 5 == 3) rand_live();
    end
  endtask
  task automatic test_banner();
    run_banner(2'b00, 27, "banner");
  endtask
  task automatic test_restart();
    run_banner(2'($urandom), 11, "pre_restart");
    run_banner(2'b01, 27, "restart");
  endtask
  task automatic test_tie();
    run_banner(2'b11, 26, "tie11");
    run_banner(2'b10, 26, "tie10");
  endtask
  task automatic test_reset_mid();
    run_banner(2'b01, 6, "pre_rst");
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (got_d() !== 16'hFFFF) begin errors++; $display("FAIL midrst_d got=%h exp=ffff", got_d()); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    rand_live();
    for (int i = 0; i < 6; i++) begin
      edge_model();
      checks += 3;
      if (got_d() !== exp_d) begin errors++; $display("FAIL midrst_live cyc=%0d got=%h exp=%h", i, got_d(), exp_d); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy2 cyc=%0d got=%b exp=0", i, bus.busy); end
      if (bus.scan_clk !== exp_scan()) begin errors++; $display("FAIL midrst_scan cyc=%0d got=%b exp=%b", i, bus.scan_clk, exp_scan()); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.res_req = $urandom_range(0, 19) == 0;
      bus.res_code = 2'($urandom);
      if ($urandom_range(0, 3) == 0) rand_live();
      edge_model();
      checks += 3;
      if (got_d() !== exp_d) begin errors++; $display("FAIL rand_d cyc=%0d got=%h exp=%h", i, got_d(), exp_d); end
      if (bus.busy !== active) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, bus.busy, active); end
      if (bus.scan_clk !== exp_scan()) begin errors++; $display("FAIL rand_scan cyc=%0d got=%b exp=%b", i, bus.scan_clk, exp_scan()); end
    end
    bus.res_req = 1'b0;
  endtask
  initial begin
    bus.res_req = 1'b0;
    bus.res_code = 2'b00;
    rand_live();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    test_reset();
    test_live();
    test_banner();
    test_restart();
    test_tie();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
